// File: rtl/temp_aggregator_pkg.sv
// Shared constants, FSM state type and tick divisor helper for the temperature
// aggregator and its prescaler.
package temp_agg_pkg;

  localparam logic [7:0]  TEMP_FAILSAFE_MIN = 8'h00;
  localparam logic [7:0]  TEMP_FAILSAFE_MAX = 8'hFF;
  localparam logic [15:0] AGE_SAT           = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    PUBLISH
  } state_t;

  function automatic int MS_DIV(input int sys_freq);
    return sys_freq / 1000;
  endfunction

endpackage

// File: rtl/temp_aggregator_tick_gen.sv
// Millisecond prescaler: one-cycle tick every SYS_FREQ/1000 clocks, restarted by rst.
module tick_gen
  import temp_agg_pkg::*;
#(
  parameter int SYS_FREQ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            DIV  = MS_DIV(SYS_FREQ);
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !rst && (cnt == LAST);

endmodule

// File: rtl/temp_aggregator.sv
// Keeps an age-tracked entry per sensor channel and periodically reduces them to
// min inlet / max outlet temperatures, falling back to fan-full-speed values.
module temp_aggregator
  import temp_agg_pkg::*;
#(
  parameter int SYS_FREQ = 100_000_000,
  parameter int N_IN     = 4,
  parameter int N_OUT    = 4,
  parameter int STALE_MS = 2000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [3:0]              s_chan,
  input  logic [7:0]              s_temp,
  input  logic                    s_err,
  output logic [7:0]              min_in_temp,
  output logic [7:0]              max_out_temp,
  output logic                    temp_valid,
  output logic [N_IN+N_OUT-1:0]   stale_mask,
  output logic                    fault
);

  localparam int          N         = N_IN + N_OUT;
  localparam logic [4:0]  N_CHAN    = 5'(N);
  localparam logic [3:0]  N_IN_IDX  = 4'(N_IN);
  localparam logic [3:0]  LAST_IDX  = 4'(N - 1);
  localparam logic [15:0] STALE_AGE = 16'(STALE_MS);

  logic tick;

  tick_gen #(
    .SYS_FREQ(SYS_FREQ)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  logic [7:0]   val     [N];
  logic [15:0]  age     [N];
  logic [15:0]  age_inc [N];
  logic [N-1:0] stale;
  logic         wr_en;

  state_t     state;
  logic [3:0] idx;
  logic [7:0] acc_min;
  logic [7:0] acc_max;
  logic [4:0] cnt_in;
  logic       pending;

  logic [7:0] cur_val;
  logic       cur_stale;
  logic       cur_inlet;
  logic       outlet_stale;
  logic       inlets_stale;

  assign s_ready = !rst;
  assign wr_en   = s_valid && s_ready && !s_err && ({1'b0, s_chan} < N_CHAN);

  always_comb begin
    for (int k = 0; k < N; k++) begin
      age_inc[k] = (age[k] == AGE_SAT) ? AGE_SAT : age[k] + 16'd1;
    end
  end

  // A fresh write takes priority over ageing when both land in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        val[k] <= '0;
        age[k] <= AGE_SAT;
      end
      stale <= '1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (wr_en && (s_chan == 4'(k))) begin
          val[k]   <= s_temp;
          age[k]   <= '0;
          stale[k] <= 1'b0;
        end else if (tick) begin
          age[k]   <= age_inc[k];
          stale[k] <= (age_inc[k] >= STALE_AGE);
        end
      end
    end
  end

  always_comb begin
    cur_val   = '0;
    cur_stale = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (idx == 4'(k)) begin
        cur_val   = val[k];
        cur_stale = stale[k];
      end
    end
  end

  assign cur_inlet    = (idx < N_IN_IDX);
  assign outlet_stale = |stale[N-1:N_IN];
  assign inlets_stale = &stale[N_IN-1:0];

  // The scan reads registered entries, so a write in a channel's scan cycle
  // only shows up in the following publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      acc_min      <= 8'hFF;
      acc_max      <= 8'h00;
      cnt_in       <= '0;
      pending      <= 1'b0;
      min_in_temp  <= TEMP_FAILSAFE_MIN;
      max_out_temp <= TEMP_FAILSAFE_MAX;
      temp_valid   <= 1'b0;
      stale_mask   <= '1;
      fault        <= 1'b0;
    end else begin
      if (tick && (state != IDLE)) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (tick || pending) begin
            state   <= SCAN;
            idx     <= '0;
            acc_min <= 8'hFF;
            acc_max <= 8'h00;
            cnt_in  <= '0;
            pending <= 1'b0;
          end
        end
        SCAN: begin
          if (!cur_stale) begin
            if (cur_inlet) begin
              if (cur_val < acc_min) begin
                acc_min <= cur_val;
              end
              cnt_in <= cnt_in + 5'd1;
            end else if (cur_val > acc_max) begin
              acc_max <= cur_val;
            end
          end
          if (idx == LAST_IDX) begin
            state <= PUBLISH;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        PUBLISH: begin
          min_in_temp  <= (cnt_in == 5'd0) ? TEMP_FAILSAFE_MIN : acc_min;
          max_out_temp <= outlet_stale ? TEMP_FAILSAFE_MAX : acc_max;
          stale_mask   <= stale;
          fault        <= outlet_stale || inlets_stale;
          temp_valid   <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temp_aggregator.sv
// Scoreboard bench for temp_aggregator: a behavioural model queues each expected
// publish and the checker compares it when the outputs are due to change.
module tb_temp_aggregator;

  localparam int SYS_FREQ = 1_000_000;
  localparam int N_IN     = 2;
  localparam int N_OUT    = 2;
  localparam int STALE_MS = 3;
  localparam int N        = N_IN + N_OUT;
  localparam int DIV      = SYS_FREQ / 1000;

  logic         clk     = 1'b0;
  logic         rst     = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_err   = 1'b0;
  logic [3:0]   s_chan  = '0;
  logic [7:0]   s_temp  = '0;
  logic         s_ready;
  logic [7:0]   min_in_temp;
  logic [7:0]   max_out_temp;
  logic         temp_valid;
  logic [N-1:0] stale_mask;
  logic         fault;

  temp_aggregator #(
    .SYS_FREQ(SYS_FREQ),
    .N_IN    (N_IN),
    .N_OUT   (N_OUT),
    .STALE_MS(STALE_MS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_chan      (s_chan),
    .s_temp      (s_temp),
    .s_err       (s_err),
    .min_in_temp (min_in_temp),
    .max_out_temp(max_out_temp),
    .temp_valid  (temp_valid),
    .stale_mask  (stale_mask),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]   min_t;
    logic [7:0]   max_t;
    logic [N-1:0] mask;
    logic         flt;
    logic         vld;
  } obs_t;

  typedef struct {
    int   due;
    obs_t exp;
  } sb_item_t;

  localparam obs_t RESET_EXP = '{min_t: 8'h00, max_t: 8'hFF, mask: {N{1'b1}}, flt: 1'b0, vld: 1'b0};

  sb_item_t sb_q[$];
  obs_t     last_exp = RESET_EXP;
  int       total = 0;
  int       bad   = 0;
  int       cyc   = 0;
  int       mcnt  = 0;
  bit       rst_edge = 1'b0;

  int m_val   [N];
  int m_age   [N];
  bit m_stale [N];
  int m_state = 0;
  int m_idx   = 0;
  int m_min   = 255;
  int m_max   = 0;
  int m_cnt   = 0;
  bit m_pend  = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic compareOutputs(input string kind, input obs_t e);
    checkOutput({kind, "_min_in"}, 32'(min_in_temp), 32'(e.min_t));
    checkOutput({kind, "_max_out"}, 32'(max_out_temp), 32'(e.max_t));
    checkOutput({kind, "_stale_mask"}, 32'(stale_mask), 32'(e.mask));
    checkOutput({kind, "_fault"}, 32'(fault), 32'(e.flt));
    checkOutput({kind, "_temp_valid"}, 32'(temp_valid), 32'(e.vld));
  endtask

  // Reference model: entry table, prescaler and scan schedule as seen from outside.
  always @(posedge clk) begin : model
    bit   tick_now;
    bit   any_out;
    bit   all_in;
    obs_t e;
    tick_now = !rst && (mcnt == DIV - 1);
    rst_edge = rst;
    if (rst) begin
      mcnt    = 0;
      m_state = 0;
      m_pend  = 1'b0;
      for (int k = 0; k < N; k++) begin
        m_val[k]   = 0;
        m_age[k]   = 65535;
        m_stale[k] = 1'b1;
      end
      sb_q.delete();
    end else begin
      if (tick_now && m_state != 0) m_pend = 1'b1;
      case (m_state)
        0: if (tick_now || m_pend) begin
          m_state = 1; m_idx = 0; m_min = 255; m_max = 0; m_cnt = 0; m_pend = 1'b0;
        end
        1: begin
          if (!m_stale[m_idx]) begin
            if (m_idx < N_IN) begin
              if (m_val[m_idx] < m_min) m_min = m_val[m_idx];
              m_cnt++;
            end else if (m_val[m_idx] > m_max) begin
              m_max = m_val[m_idx];
            end
          end
          if (m_idx == N - 1) m_state = 2;
          else m_idx++;
        end
        default: begin
          any_out = 1'b0;
          all_in  = 1'b1;
          for (int k = 0; k < N; k++) begin
            e.mask[k] = m_stale[k];
            if (k >= N_IN) any_out = any_out | m_stale[k];
            else all_in = all_in & m_stale[k];
          end
          e.min_t = (m_cnt == 0) ? 8'h00 : 8'(m_min);
          e.max_t = any_out ? 8'hFF : 8'(m_max);
          e.flt   = any_out || all_in;
          e.vld   = 1'b1;
          sb_q.push_back('{due: cyc + 1, exp: e});
          m_state = 0;
        end
      endcase
      for (int k = 0; k < N; k++) begin
        if (s_valid && !s_err && (int'(s_chan) == k)) begin
          m_val[k]   = int'(s_temp);
          m_age[k]   = 0;
          m_stale[k] = 1'b0;
        end else if (tick_now) begin
          if (m_age[k] < 65535) m_age[k]++;
          m_stale[k] = (m_age[k] >= STALE_MS);
        end
      end
      mcnt = (mcnt == DIV - 1) ? 0 : mcnt + 1;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (rst_edge) begin
      last_exp = RESET_EXP;
      compareOutputs("reset", last_exp);
    end else if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      last_exp = sb_q[0].exp;
      void'(sb_q.pop_front());
      compareOutputs("publish", last_exp);
    end else if (cyc % 8 == 0) begin
      compareOutputs("hold", last_exp);
    end
    checkOutput("s_ready", 32'(s_ready), 32'(!rst));
  end

  task automatic applyStimulus(input int chan, input int temp, input bit err);
    s_valid = 1'b1;
    s_chan  = 4'(chan);
    s_temp  = 8'(temp);
    s_err   = err;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_err   = 1'b0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitPhase(input int phase);
    for (int i = 0; i < DIV + 2; i++) begin
      if (mcnt == phase) break;
      @(posedge clk);
      #1;
    end
    if (mcnt != phase) checkOutput("phase_wait", 32'(mcnt), 32'(phase));
  endtask

  task automatic nextPublish();
    waitPhase(DIV - 1);
    runCycles(N + 4);
  endtask

  initial begin
    runCycles(5);
    rst = 1'b0;

    // No samples yet: everything stale, fail-safe outputs.
    nextPublish();

    // Normal reduction with all channels refreshed every ms.
    repeat (3) begin
      waitPhase(20);
      applyStimulus(0, 50, 1'b0);
      applyStimulus(1, 44, 1'b0);
      applyStimulus(2, 60, 1'b0);
      applyStimulus(3, 70, 1'b0);
      nextPublish();
    end

    // ch3 left to go stale, then refreshed.
    repeat (5) begin
      waitPhase(20);
      applyStimulus(0, 50, 1'b0);
      applyStimulus(1, 44, 1'b0);
      applyStimulus(2, 60, 1'b0);
      nextPublish();
    end
    waitPhase(20);
    applyStimulus(3, 66, 1'b0);
    nextPublish();

    // ch1 only sees failed reads; out-of-range channel must be ignored.
    repeat (5) begin
      waitPhase(20);
      applyStimulus(0, 52, 1'b0);
      applyStimulus(1, 0, 1'b1);
      applyStimulus(2, 61, 1'b0);
      applyStimulus(3, 66, 1'b0);
      applyStimulus(7, 1, 1'b0);
      nextPublish();
    end

    // Write on the tick cycle, then during the idx-0 scan cycle.
    waitPhase(20);
    applyStimulus(0, 52, 1'b0);
    applyStimulus(3, 66, 1'b0);
    waitPhase(DIV - 1);
    applyStimulus(2, 90, 1'b0);
    applyStimulus(0, 10, 1'b0);
    runCycles(N + 4);
    repeat (4) begin
      waitPhase(20);
      applyStimulus(0, 10, 1'b0);
      applyStimulus(3, 66, 1'b0);
      nextPublish();
    end

    // Reset in the middle of a scan.
    waitPhase(DIV - 1);
    runCycles(2);
    rst = 1'b1;
    runCycles(1);
    rst = 1'b0;
    runCycles(4);
    nextPublish();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/temp_aggregator.md
# temp_aggregator

Collects per-sensor temperature samples from the sensor-polling front end and reduces them to the two values the fan PWM controller consumes: minimum inlet temperature and maximum outlet temperature.
- Every sample is age-tracked, and sensors that go silent are flagged stale.
- Missing data drives the outputs to fail-safe values that push the fan to full speed.
- The block sits directly between the sensor reader and the fan controller.

## Interface
Parameters:
- SYS_FREQ, 100_000_000: clk frequency in Hz; the 1 ms tick divisor is SYS_FREQ/1000.
- N_IN, 4: number of inlet sensors, channels 0..N_IN-1.
- N_OUT, 4: number of outlet sensors, channels N_IN..N_IN+N_OUT-1. N_IN+N_OUT ≤ 16.
- STALE_MS, 2000: age in ms at or beyond which an entry is stale; 16-bit range.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- s_valid  in  1  sample present.
- s_ready  out  1  block accepts the sample this cycle.
- s_chan  in  4  sensor channel index.
- s_temp  in  8  temperature, unsigned, 0.5 °C per LSB.
- s_err  in  1  sensor read failed; s_temp is invalid.
- min_in_temp  out  8  minimum temperature over fresh inlet sensors, 0.5 °C units.
- max_out_temp  out  8  maximum temperature over fresh outlet sensors, 0.5 °C units.
- temp_valid  out  1  high once the first publish has completed.
- stale_mask  out  N_IN+N_OUT  bit k set = channel k is stale.
- fault  out  1  any outlet stale, or all inlets stale.

## Operation
- **Entry table.** One entry per channel: val[7:0], age[15:0] (saturating at 16'hFFFF), stale bit.
  - Reset: val=0, age=16'hFFFF, stale=1.
- **Accept rule.** A sample is accepted when s_valid && s_ready. s_ready = !rst; samples are accepted back-to-back.
- **Write rule** (accepted sample with s_err=0 and s_chan < N_IN+N_OUT): val=s_temp, age=0, stale=0.
  - s_err=1: entry untouched, so age keeps running.
  - s_chan out of range: sample dropped, no state change.
- **Ageing.** On each ms tick every entry gets age+1 (saturating). stale = (age ≥ STALE_MS).
  - A write in the same cycle as a tick wins: age=0.
- **FSM: IDLE, SCAN, PUBLISH.**
  - IDLE: on ms tick or pending flag → SCAN, with idx=0, acc_min=8'hFF, acc_max=8'h00, cnt_in=0.
  - SCAN: one entry per cycle, idx 0..N-1, using registered (pre-write) entry values.
    - Inlet entries that are not stale: acc_min=min(acc_min, val), cnt_in++.
    - Outlet entries that are not stale: acc_max=max(acc_max, val).
    - After idx=N-1 → PUBLISH.
  - PUBLISH (one cycle): register the outputs, then → IDLE.
    - min_in_temp = (cnt_in==0) ? 8'h00 : acc_min.
    - max_out_temp = (any outlet stale) ? 8'hFF : acc_max.
    - stale_mask and fault are snapshotted at the same time; temp_valid=1.
- **Fail-safe.** 8'h00 on the inlet value and 8'hFF on the outlet value both force maximum fan speed downstream.
- **Pending flag.** A tick arriving while not in IDLE sets pending. Pending is cleared on entry to SCAN. At most one scan is queued.
- **Mid-scan reset.** rst returns the FSM to IDLE and all outputs to their reset values.

## Timing
- Output reset values:
  - min_in_temp=8'h00, max_out_temp=8'hFF, temp_valid=0.
  - stale_mask=all ones, fault=0, s_ready=0 while rst is high.
- Tick at cycle T:
  - SCAN occupies T+1..T+N.
  - PUBLISH at T+N+1.
  - New outputs are visible at T+N+2.
- A sample accepted at cycle W is visible to a scan whose SCAN cycle for that channel is ≥ W+1.
- Outputs are stable between publishes; they change only on the cycle after PUBLISH.
- First tick occurs SYS_FREQ/1000 cycles after rst deasserts.

## Structure
- Package temp_agg_pkg:
  - TEMP_FAILSAFE_MIN=8'h00, TEMP_FAILSAFE_MAX=8'hFF.
  - AGE_SAT=16'hFFFF.
  - State enum {IDLE, SCAN, PUBLISH}.
  - MS_DIV(SYS_FREQ) function.
- Sub-module tick_gen: a prescaler that emits a one-cycle tick every SYS_FREQ/1000 clocks; counter resets on rst.
- Entry table, ageing logic and FSM stay in temp_aggregator.

## Test plan
Sim parameters: SYS_FREQ=1_000_000 (tick every 1000 cycles), N_IN=2, N_OUT=2, STALE_MS=3.
- **No samples after reset** → first publish gives min_in_temp=8'h00, max_out_temp=8'hFF, stale_mask=4'b1111, fault=1, temp_valid=1.
- **Normal reduction.** Write ch0=50, ch1=44, ch2=60, ch3=70, refreshed every ms → min_in_temp=44, max_out_temp=70, fault=0, stale_mask=0.
- **Outlet goes stale.** Stop refreshing ch3 while refreshing the others, with ch3 last written at time t → at the first publish with age≥3: stale_mask=4'b1000, max_out_temp=8'hFF, fault=1. Writing ch3=66 → next publish gives max_out_temp=66, fault=0.
- **Error and range handling.** s_err=1 sample on ch1 with s_temp=0 → ch1 value unchanged and ch1 still ages. s_chan=7 → no state change.
- **Simultaneity.** Write ch2 on the same cycle as the tick → ch2 age=0, not stale. Write ch0=10 during the SCAN cycle for idx 0 → that publish shows the old value and the next publish shows 10. Assert rst during SCAN → outputs return to their reset values the next cycle.
